led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 141 ++++++++++++++
 tb/tb_led_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer: blink, chaser, binary counter and ping-pong patterns,
// one step every period+1 clocks, for a fixed number of steps or until stopped.
module led_sequencer #(
  parameter int OUTPUT_SIZE = 4,
  parameter int PER_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [PER_WIDTH-1:0]   period,
  input  logic [7:0]             steps,
  output logic [OUTPUT_SIZE-1:0] led,
  output logic                   busy,
  output logic                   done,
  output logic [0:0]             dbg_state
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] MODE_BLINK    = 2'd0;
  localparam logic [1:0] MODE_CHASER   = 2'd1;
  localparam logic [1:0] MODE_COUNTER  = 2'd2;
  localparam logic [1:0] MODE_PINGPONG = 2'd3;

  localparam logic [OUTPUT_SIZE-1:0] LED_ONE = OUTPUT_SIZE'(1);

  logic [0:0]             state;
  logic [1:0]             mode_q;
  logic [PER_WIDTH-1:0]   period_q;
  logic [PER_WIDTH-1:0]   presc;
  logic [7:0]             steps_q;
  logic [7:0]             cnt;
  logic                   dir_left;

  logic                   tick;
  logic [7:0]             cnt_next;
  logic [OUTPUT_SIZE-1:0] led_init;
  logic [OUTPUT_SIZE-1:0] led_next;
  logic                   dir_next;

  assign tick      = (presc == period_q);
  assign cnt_next  = cnt + 8'd1;
  assign dbg_state = state;

  always_comb begin
    led_init = '0;
    case (mode)
      MODE_BLINK:    led_init = '1;
      MODE_CHASER:   led_init = LED_ONE;
      MODE_COUNTER:  led_init = '0;
      MODE_PINGPONG: led_init = LED_ONE;
      default:       led_init = '0;
    endcase
  end

  // Ping-pong turns around on the step that leaves an end bit, so each end is lit exactly once.
  always_comb begin
    led_next = led;
    dir_next = dir_left;
    case (mode_q)
      MODE_BLINK:   led_next = ~led;
      MODE_CHASER:  led_next = {led[OUTPUT_SIZE-2:0], led[OUTPUT_SIZE-1]};
      MODE_COUNTER: led_next = led + LED_ONE;
      MODE_PINGPONG: begin
        if (dir_left) begin
          if (led[OUTPUT_SIZE-1]) begin
            led_next = led >> 1;
            dir_next = 1'b0;
          end else begin
            led_next = led << 1;
          end
        end else begin
          if (led[0]) begin
            led_next = led << 1;
            dir_next = 1'b1;
          end else begin
            led_next = led >> 1;
          end
        end
      end
      default: led_next = led;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      presc    <= '0;
      cnt      <= '0;
      dir_left <= 1'b1;
      mode_q   <= '0;
      period_q <= '0;
      steps_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state    <= RUN;
            busy     <= 1'b1;
            mode_q   <= mode;
            period_q <= period;
            steps_q  <= steps;
            led      <= led_init;
            presc    <= '0;
            cnt      <= '0;
            dir_left <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            led   <= '0;
            presc <= '0;
          end else begin
            presc <= tick ? '0 : presc + PER_WIDTH'(1);
            if (tick) begin
              led      <= led_next;
              dir_left <= dir_next;
              cnt      <= (cnt == 8'hFF) ? cnt : cnt_next;
              if (steps_q != 8'd0 && cnt_next == steps_q) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Cycle-accurate scoreboard bench for led_sequencer: every cycle's {busy,done,led}
// is predicted from closed-form pattern formulas and compared one clock later.
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [15:0] period;
  logic [7:0]  steps;
  logic [3:0]  led;
  logic        busy;
  logic        done;
  logic [0:0]  dbg_state;

  int          errors = 0;
  int          checks = 0;
  logic [5:0]  exp_q[$];
  logic [5:0]  exp_e;
  logic [3:0]  exp_led;

  led_sequencer #(.OUTPUT_SIZE(4), .PER_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .period(period), .steps(steps), .led(led), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected pattern after k steps of a given mode (4-bit LEDs).
  function automatic logic [3:0] pat(input int m, input int k);
    int idx;
    int pos;
    logic [3:0] one;
    one = 4'b0001;
    case (m)
      0: return (k % 2 == 0) ? 4'hF : 4'h0;
      1: return one << (k % 4);
      2: return 4'(k % 16);
      default: begin
        idx = k % 6;
        pos = (idx <= 3) ? idx : 6 - idx;
        return one << pos;
      end
    endcase
  endfunction

  // Scoreboard: one expectation per cycle, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      chk("cycle {busy,done,led}", {26'd0, busy, done, led}, {26'd0, exp_e});
    end
  end

  task automatic scramble_inputs();
    start  = 1'($urandom_range(0, 1));
    mode   = 2'($urandom_range(0, 3));
    period = 16'($urandom_range(0, 65535));
    steps  = 8'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      exp_q.push_back({2'b00, exp_led});
    end
  endtask

  task automatic launch(input int m, input int p, input int n);
    @(negedge clk);
    mode   = 2'(m);
    period = 16'(p);
    steps  = 8'(n);
    start  = 1'b1;
    stop   = 1'b0;
    exp_q.push_back({2'b10, pat(m, 0)});
  endtask

  task automatic run_fin(input int m, input int p, input int n);
    launch(m, p, n);
    for (int s = 1; s < n * (p + 1); s++) begin
      @(negedge clk);
      scramble_inputs();
      exp_q.push_back({2'b10, pat(m, s / (p + 1))});
    end
    @(negedge clk);
    scramble_inputs();
    exp_q.push_back({2'b01, pat(m, n)});
    exp_led = pat(m, n);
  endtask

  task automatic run_inf(input int m, input int p, input int c, input bit do_stop);
    launch(m, p, 0);
    for (int s = 1; s < c; s++) begin
      @(negedge clk);
      scramble_inputs();
      exp_q.push_back({2'b10, pat(m, s / (p + 1))});
    end
    if (do_stop) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b1;
      exp_q.push_back(6'b00_0000);
      exp_led = 4'h0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    mode = 2'd0; period = 16'd0; steps = 8'd0;
    exp_led = 4'h0;
    #3;
    chk("reset led", {28'd0, led}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    run_fin(1, 1, 5);   // chaser, step every 2 clocks, ends on 0010
    idle(2);

    @(negedge clk);     // start with stop in IDLE: no launch, led held
    start = 1'b1;
    stop  = 1'b1;
    exp_q.push_back({2'b00, exp_led});
    idle(1);

    run_fin(2, 0, 17);  // counter wraps through 0000 and ends on 0001
    run_fin(1, 0, 3);   // start coincident with the done pulse
    idle(2);

    run_fin(0, 3, 4);   // blink with mid-run input changes
    idle(1);

    run_inf(3, 0, 8, 1'b1);   // ping-pong bounce then stop
    idle(2);

    run_inf(1, 2, 6, 1'b1);   // stop on the same cycle as a tick
    idle(1);

    run_inf(0, 0, 300, 1'b1); // free-running past the step counter saturation
    idle(1);

    run_inf(2, 0, 7, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("async reset led", {28'd0, led}, 32'd0);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_led = 4'h0;
    idle(2);
    run_fin(1, 1, 5);
    idle(2);

    @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
